// File: rtl/line_fill_responder.sv
// -----------------------------------------------------------------------------
// line_fill_responder
//
// Memory-side responder for data cache line traffic. One line request is taken
// at a time over a valid/ready handshake:
//   - read  (refill)     : after LATENCY idle cycles, BURST_LEN words stream
//                          out on consecutive cycles (no backpressure).
//   - write (write-back) : BURST_LEN words are absorbed (gaps allowed), then
//                          after LATENCY idle cycles a one-cycle wr_done pulse.
// The backing store is a MEM_WORDS deep word array, not cleared by reset.
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   req_valid     : request offered          req_ready  : request accepted
//   req_write     : 1 = write-back, 0 = refill read
//   req_addr      : byte address anywhere inside the target line
//   wdata_valid   : write beat offered       wdata_ready: write beat accepted
//   wdata         : write beat data
//   rdata_valid   : read beat valid          rdata_last : final read beat
//   rdata         : read beat data (registered, holds last beat)
//   wr_done       : one-cycle write completion pulse
// -----------------------------------------------------------------------------
module line_fill_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int LATENCY    = 3,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  wr_done
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    // Read wait is entered on the handshake edge, so it counts one less; the
    // transition into the burst uses the final wait cycle.
    localparam logic [LAT_W-1:0]  RD_WAIT_LOAD = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    // Write wait: wr_done is raised in the cycle where the counter hits zero.
    localparam logic [LAT_W-1:0]  WR_WAIT_LOAD = LAT_W'(LATENCY);
    localparam logic [IDX_W-1:0]  LINE_MASK    = ~IDX_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RWAIT,
        S_RBURST,
        S_WDATA,
        S_WWAIT
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] base;
        logic             write;
    } line_req_t;

    state_t                state_q, state_d;
    line_req_t             req_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [LAT_W-1:0]      lat_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  hs;
    logic [IDX_W-1:0]      req_base;
    logic                  beat_end;
    logic                  lat_zero;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_load;
    logic [IDX_W-1:0]      fetch_base;
    logic [BEAT_W-1:0]     fetch_beat;
    logic [IDX_W-1:0]      fetch_idx;

    // Byte offset and bits above the array are dropped; the latched write flag
    // is kept for debug visibility only.
    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_q.write};

    assign hs       = req_valid & req_ready;
    assign req_base = req_addr[IDX_W+1:2] & LINE_MASK;
    assign beat_end = (beat_q == LAST_BEAT);
    assign lat_zero = (lat_q == '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (req_write)         state_d = S_WDATA;
                    else if (LATENCY == 0) state_d = S_RBURST;
                    else                   state_d = S_RWAIT;
                end
            end
            S_RWAIT:  if (lat_zero) state_d = S_RBURST;
            S_RBURST: if (beat_end) state_d = S_IDLE;
            S_WDATA:  if (wdata_valid && beat_end) state_d = S_WWAIT;
            S_WWAIT:  if (lat_zero) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        wr_done     = 1'b0;
        unique case (state_q)
            // State is already IDLE during reset; gate ready so nothing is
            // accepted until reset is released.
            S_IDLE:   req_ready = ~rst;
            S_RBURST: begin
                rdata_valid = 1'b1;
                rdata_last  = beat_end;
            end
            S_WDATA:  wdata_ready = 1'b1;
            S_WWAIT:  wr_done = lat_zero;
            default:  ;
        endcase
    end

    assign rdata = rdata_q;

    // ---------------- request, beat and latency counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= '0;
            beat_q <= '0;
            lat_q  <= '0;
        end else begin
            if (hs) begin
                req_q.base  <= req_base;
                req_q.write <= req_write;
                beat_q      <= '0;
                lat_q       <= RD_WAIT_LOAD;
            end
            if (state_q == S_RBURST) begin
                beat_q <= beat_q + 1'b1;
            end
            if (wr_en) begin
                beat_q <= beat_q + 1'b1;
                if (beat_end) lat_q <= WR_WAIT_LOAD;
            end
            if ((state_q == S_RWAIT || state_q == S_WWAIT) && !lat_zero) begin
                lat_q <= lat_q - 1'b1;
            end
        end
    end

    // ---------------- array write ----------------
    // Lines are aligned, so OR-ing in the beat never carries out of the line.
    assign wr_en  = (state_q == S_WDATA) && wdata_valid;
    assign wr_idx = req_q.base | IDX_W'(beat_q);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wdata;
    end

    // ---------------- registered read path ----------------
    // rdata is loaded on the edge that enters each beat. The first beat comes
    // from the incoming address when a zero-latency read skips the wait state.
    assign rd_load    = (state_d == S_RBURST);
    assign fetch_base = (state_q == S_IDLE) ? req_base : req_q.base;
    assign fetch_beat = (state_q == S_RBURST) ? beat_q + 1'b1 : '0;
    assign fetch_idx  = fetch_base | IDX_W'(fetch_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= mem[fetch_idx];
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_line_fill_responder
//
// Two responders (LATENCY=3 and LATENCY=0) see the same stimulus. A timeline
// model (absolute cycle numbers for beats, completion and readiness, plus a
// word array per instance) predicts every output on every cycle. A table of
// line writes/reads with expected data and latencies drives the directed part;
// reset handling and a randomized phase follow.
// -----------------------------------------------------------------------------
module tb_line_fill_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BL = 4;
    localparam int MW = 1024;
    localparam int NV = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [1:0]           req_valid = '0;
    logic                 req_write = 1'b0;
    logic [AW-1:0]        req_addr = '0;
    logic                 wdata_valid = 1'b0;
    logic [DW-1:0]        wdata = '0;
    logic [1:0]           req_ready, wdata_ready, rdata_valid, rdata_last, wr_done;
    logic [1:0][DW-1:0]   rdata;

    always #5 clk = ~clk;

    line_fill_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
                          .LATENCY(3), .MEM_WORDS(MW)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready[0]),
        .rdata_valid(rdata_valid[0]), .rdata(rdata[0]), .rdata_last(rdata_last[0]),
        .wr_done(wr_done[0])
    );

    line_fill_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
                          .LATENCY(0), .MEM_WORDS(MW)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready[1]),
        .rdata_valid(rdata_valid[1]), .rdata(rdata[1]), .rdata_last(rdata_last[1]),
        .wr_done(wr_done[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic int line_base(input logic [AW-1:0] a);
        int idx;
        idx = int'((a >> 2) % MW);
        return idx - (idx % BL);
    endfunction

    task automatic chk(input string name, input int inst, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // mode: 0 idle, 1 read in flight, 2 collecting write beats, 3 write pending
    logic [DW-1:0] m_mem [2][MW];
    logic [DW-1:0] m_last [2] = '{'0, '0};
    int m_mode [2]  = '{0, 0};
    int m_base [2]  = '{0, 0};
    int m_cnt [2]   = '{0, 0};
    int m_first [2] = '{0, 0};
    int m_done [2]  = '{0, 0};

    // Each negedge is labelled with the number of the rising edge that follows.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic          e_rv, e_rl, e_done;
            logic [DW-1:0] e_rd;
            e_rv   = !rst && m_mode[i] == 1 && cyc >= m_first[i];
            e_rl   = e_rv && cyc == m_first[i] + BL - 1;
            e_done = !rst && m_mode[i] == 3 && cyc == m_done[i];
            if (rst)       e_rd = '0;
            else if (e_rv) e_rd = m_mem[i][m_base[i] + cyc - m_first[i]];
            else           e_rd = m_last[i];
            chk("req_ready",   i, DW'(req_ready[i]),   DW'(!rst && m_mode[i] == 0));
            chk("wdata_ready", i, DW'(wdata_ready[i]), DW'(!rst && m_mode[i] == 2));
            chk("rdata_valid", i, DW'(rdata_valid[i]), DW'(e_rv));
            chk("rdata_last",  i, DW'(rdata_last[i]),  DW'(e_rl));
            chk("wr_done",     i, DW'(wr_done[i]),     DW'(e_done));
            chk("rdata",       i, rdata[i],            e_rd);

            if (rst) begin
                m_mode[i] = 0;
                m_last[i] = '0;
            end else begin
                case (m_mode[i])
                    0: if (req_valid[i]) begin
                        m_base[i] = line_base(req_addr);
                        if (req_write) begin
                            m_mode[i] = 2;
                            m_cnt[i]  = 0;
                        end else begin
                            m_mode[i]  = 1;
                            m_first[i] = cyc + 1 + lat_of(i);
                        end
                    end
                    1: if (cyc >= m_first[i]) begin
                        m_last[i] = m_mem[i][m_base[i] + cyc - m_first[i]];
                        if (cyc == m_first[i] + BL - 1) m_mode[i] = 0;
                    end
                    2: if (wdata_valid) begin
                        m_mem[i][m_base[i] + m_cnt[i]] = wdata;
                        m_cnt[i]++;
                        if (m_cnt[i] == BL) begin
                            m_mode[i] = 3;
                            m_done[i] = cyc + lat_of(i) + 1;
                        end
                    end
                    3: if (cyc == m_done[i]) m_mode[i] = 0;
                    default: m_mode[i] = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct packed {
        logic               wr;
        logic               gap;
        logic               noise;
        logic [AW-1:0]      addr;
        logic [BL-1:0][DW-1:0] dat;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic gap, input logic noise,
                                input logic [AW-1:0] a, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [DW-1:0] d3);
        vec_t v;
        v.wr = wr; v.gap = gap; v.noise = noise; v.addr = a;
        v.dat = {d3, d2, d1, d0};
        return v;
    endfunction

    logic [DW-1:0] rd_got [2][BL];
    int rd_n [2], rd_first [2], rd_lastj [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (req_ready !== 2'b11 && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle", 0, DW'(req_ready), DW'(2'b11));
    endtask

    task automatic do_req(input logic [1:0] who, input logic wr, input logic [AW-1:0] a);
        wait_idle();
        req_valid = who;
        req_write = wr;
        req_addr  = a;
        tick();
        req_valid = '0;
    endtask

    task automatic write_line(input logic [AW-1:0] a, input logic [BL-1:0][DW-1:0] d,
                              input logic gap);
        int dj [2];
        int dn [2];
        do_req(2'b11, 1'b1, a);
        for (int k = 0; k < BL; k++) begin
            wdata_valid = 1'b1;
            wdata       = d[k];
            tick();
            wdata_valid = 1'b0;
            if (gap && k == 1) begin
                tick();
                tick();
            end
        end
        dj = '{-1, -1};
        dn = '{0, 0};
        for (int j = 1; j <= 8; j++) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_done[i]) begin
                    if (dn[i] == 0) dj[i] = j;
                    dn[i]++;
                end
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk("wr_done_delay", i, DW'(dj[i]), DW'(lat_of(i) + 1));
            chk("wr_done_count", i, DW'(dn[i]), DW'(1));
        end
    endtask

    task automatic read_line(input logic [AW-1:0] a, input logic noise);
        for (int i = 0; i < 2; i++) begin
            rd_n[i] = 0; rd_first[i] = -1; rd_lastj[i] = -1;
        end
        do_req(2'b11, 1'b0, a);
        for (int j = 1; j <= 12; j++) begin
            if (noise) begin
                // write beats during the wait, a request during the burst
                wdata_valid = (j <= 3);
                wdata       = 32'hDEAD_0000 + DW'(j);
                req_write   = 1'b1;
                req_valid   = (j >= 4 && j <= 7) ? 2'b01 : 2'b00;
            end
            for (int i = 0; i < 2; i++) begin
                if (rdata_valid[i]) begin
                    if (rd_n[i] < BL) rd_got[i][rd_n[i]] = rdata[i];
                    if (rd_n[i] == 0) rd_first[i] = j;
                    if (rdata_last[i]) rd_lastj[i] = j;
                    rd_n[i]++;
                end
            end
            tick();
        end
        wdata_valid = 1'b0;
        req_valid   = '0;
        req_write   = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    vec_t vt [NV];

    initial begin
        int wd [2];
        logic [BL-1:0][DW-1:0] rnd;

        vt[0]  = mk(1, 0, 0, 32'h0000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vt[1]  = mk(0, 0, 0, 32'h0000_0106, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vt[2]  = mk(1, 1, 0, 32'h0000_0040, 32'h11, 32'h22, 32'h33, 32'h44);
        vt[3]  = mk(0, 0, 0, 32'h0000_004C, 32'h11, 32'h22, 32'h33, 32'h44);
        vt[4]  = mk(0, 0, 1, 32'h0000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vt[5]  = mk(0, 0, 0, 32'h0000_0103, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        vt[6]  = mk(1, 0, 0, 32'hFFFF_F240, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        vt[7]  = mk(0, 0, 0, 32'h0000_0244, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        vt[8]  = mk(1, 0, 0, 32'h0000_0FF0, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        vt[9]  = mk(0, 0, 0, 32'h1234_5FFC, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        vt[10] = mk(1, 0, 0, 32'h0000_0080, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        vt[11] = mk(0, 0, 0, 32'h0000_008F, 32'hC0, 32'hC1, 32'hC2, 32'hC3);

        // reset held for three cycles: every output low
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                chk("reset_ctrl", i, DW'({req_ready[i], wdata_ready[i], rdata_valid[i],
                                          rdata_last[i], wr_done[i]}), DW'(0));
                chk("reset_rdata", i, rdata[i], DW'(0));
            end
        end
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 0, DW'(req_ready), DW'(2'b11));

        // table-driven line transfers
        for (int r = 0; r < NV; r++) begin
            if (vt[r].wr) begin
                write_line(vt[r].addr, vt[r].dat, vt[r].gap);
            end else begin
                read_line(vt[r].addr, vt[r].noise);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("row%0d_beats", r), i, DW'(rd_n[i]), DW'(BL));
                    chk($sformatf("row%0d_first", r), i, DW'(rd_first[i]), DW'(lat_of(i) + 1));
                    chk($sformatf("row%0d_last", r), i, DW'(rd_lastj[i]), DW'(lat_of(i) + BL));
                    for (int k = 0; k < BL; k++)
                        chk($sformatf("row%0d_data%0d", r, k), i, rd_got[i][k], vt[r].dat[k]);
                end
            end
        end

        // reset after two accepted write beats of line 0x80
        do_req(2'b11, 1'b1, 32'h0000_0084);
        wdata_valid = 1'b1; wdata = 32'hE0; tick();
        wdata = 32'hE1; tick();
        wdata = 32'hE2; rst = 1'b1; tick();
        for (int i = 0; i < 2; i++)
            chk("midwrite_reset_ctrl", i, DW'({req_ready[i], wdata_ready[i], wr_done[i]}), DW'(0));
        tick();
        rst = 1'b0; wdata_valid = 1'b0;
        wd = '{0, 0};
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 2; i++) if (wr_done[i]) wd[i]++;
            tick();
        end
        for (int i = 0; i < 2; i++) chk("aborted_wr_done", i, DW'(wd[i]), DW'(0));
        read_line(32'h0000_0080, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("aborted_beats", i, DW'(rd_n[i]), DW'(BL));
            chk("aborted_w0", i, rd_got[i][0], 32'hE0);
            chk("aborted_w1", i, rd_got[i][1], 32'hE1);
            chk("aborted_w2", i, rd_got[i][2], 32'hC2);
            chk("aborted_w3", i, rd_got[i][3], 32'hC3);
        end

        // randomized traffic over lines 0..7 (aliased through random upper bits)
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < BL; k++) rnd[k] = $urandom;
            write_line(AW'(l * 16), rnd, 1'b0);
        end
        for (int c = 0; c < 500; c++) begin
            req_valid   = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            req_write   = 1'($urandom_range(0, 1));
            req_addr    = $urandom & 32'hFFFF_F07F;
            wdata_valid = $urandom_range(0, 9) < 7;
            wdata       = $urandom;
            rst         = $urandom_range(0, 149) == 0;
            tick();
        end
        rst = 1'b0; req_valid = '0; wdata_valid = 1'b0;
        for (int c = 0; c < 20; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
